seq_divide: RTL and testbench

Multi-cycle, parametrised integer divider for the mini CPU execute stage, successor to the combinational `divide` block. It runs one non-restoring iteration per clock, selects signed or unsigned operation per request, and reports divide-by-zero. A start/busy/done handshake lets the pipeline stall on it. Signed results follow C semantics: the quotient truncates toward zero and the remainder takes the sign of the dividend.

---
 rtl/div_pkg.sv | 26 ++
 rtl/div_step.sv | 25 ++
 rtl/seq_divide.sv | 127 ++++++++++++
 tb/tb_seq_divide.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider: state encoding and
// the counter-width helper.
package div_pkg;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ITER = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    typedef enum logic [1:0] {
        IDLE = S_IDLE,
        ITER = S_ITER,
        FIX  = S_FIX,
        DONE = S_DONE
    } state_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) result = i + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/div_step.sv
// One non-restoring iteration: shift {partial remainder, quotient} left,
// then add or subtract the divisor depending on the old remainder sign.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   pr_in,
    input  logic [WIDTH-1:0] q_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   pr_out,
    output logic [WIDTH-1:0] q_out
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] divisor_ext;

    // Intermediate overflow of the shift is harmless: the result always lands
    // back in [-divisor, divisor), which fits in WIDTH+1 signed bits.
    always_comb begin
        shifted     = {pr_in[WIDTH-1:0], q_in[WIDTH-1]};
        divisor_ext = {1'b0, divisor};
        pr_out      = pr_in[WIDTH] ? (shifted + divisor_ext) : (shifted - divisor_ext);
        q_out       = {q_in[WIDTH-2:0], ~pr_out[WIDTH]};
    end

endmodule

// File: rtl/seq_divide.sv
// Multi-cycle signed/unsigned divider with start/busy/done handshake and
// divide-by-zero reporting; C semantics for signed results.
module seq_divide
    import div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CW = clog2(WIDTH);

    state_t           state;
    state_t           next_state;
    logic             sign_mode;
    logic             dividend_neg;
    logic             divisor_neg;
    logic [WIDTH:0]   pr;
    logic [WIDTH-1:0] q_work;
    logic [WIDTH-1:0] div_mag;
    logic [CW-1:0]    cnt;

    logic             dividend_neg_in;
    logic             divisor_neg_in;
    logic [WIDTH-1:0] dividend_abs;
    logic [WIDTH-1:0] divisor_abs;
    logic [WIDTH:0]   step_pr;
    logic [WIDTH-1:0] step_q;
    logic [WIDTH-1:0] fix_rem;
    logic [WIDTH-1:0] q_result;
    logic [WIDTH-1:0] r_result;

    // Two's-complement negation of MIN wraps to 2^(WIDTH-1), which is the
    // correct magnitude when the result is read as unsigned.
    always_comb begin
        dividend_neg_in = is_signed & dividend[WIDTH-1];
        divisor_neg_in  = is_signed & divisor[WIDTH-1];
        dividend_abs    = dividend_neg_in ? -dividend : dividend;
        divisor_abs     = divisor_neg_in ? -divisor : divisor;
        fix_rem         = pr[WIDTH] ? (pr[WIDTH-1:0] + div_mag) : pr[WIDTH-1:0];
        q_result        = (sign_mode & (dividend_neg ^ divisor_neg)) ? -q_work : q_work;
        r_result        = (sign_mode & dividend_neg) ? -fix_rem : fix_rem;
    end

    div_step #(.WIDTH(WIDTH)) u_step (
        .pr_in   (pr),
        .q_in    (q_work),
        .divisor (div_mag),
        .pr_out  (step_pr),
        .q_out   (step_q)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (start) next_state = (divisor == '0) ? DONE : ITER;
            ITER: if (cnt == '0) next_state = FIX;
            FIX:  next_state = DONE;
            DONE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sign_mode    <= 1'b0;
            dividend_neg <= 1'b0;
            divisor_neg  <= 1'b0;
            pr           <= '0;
            q_work       <= '0;
            div_mag      <= '0;
            cnt          <= '0;
            quotient     <= '0;
            remainder    <= '0;
            div_by_zero  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sign_mode    <= is_signed;
                        dividend_neg <= dividend_neg_in;
                        divisor_neg  <= divisor_neg_in;
                        pr           <= '0;
                        q_work       <= dividend_abs;
                        div_mag      <= divisor_abs;
                        cnt          <= CW'(WIDTH - 1);
                        if (divisor == '0) begin
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end
                    end
                end
                ITER: begin
                    pr     <= step_pr;
                    q_work <= step_q;
                    cnt    <= cnt - CW'(1);
                end
                FIX: begin
                    quotient    <= q_result;
                    remainder   <= r_result;
                    div_by_zero <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_seq_divide.sv
// Directed bench for seq_divide at WIDTH=32: results, latency, divide-by-zero,
// ignored start while busy and mid-operation reset.
module tb_seq_divide;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             is_signed = 1'b0;
    logic [WIDTH-1:0] dividend = '0;
    logic [WIDTH-1:0] divisor = '0;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    seq_divide #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .is_signed   (is_signed),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .quotient    (quotient),
        .remainder   (remainder)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total++;
        assert (observed === expected) passed++;
        else $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    endtask

    // Latency counts negedges from the start cycle to the done cycle; inject_at
    // raises a one-cycle 9/3 start at that count while the divider is busy.
    task automatic applyStimulus(input logic sgn, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input int inject_at, output int lat, output int busy_cycles);
        @(negedge clk);
        start = 1'b1; is_signed = sgn; dividend = a; divisor = b;
        lat = 0; busy_cycles = 0;
        @(negedge clk);
        start = 1'b0; lat = 1;
        while (!done && lat < 100) begin
            if (busy) busy_cycles++;
            if (lat == inject_at) begin
                start = 1'b1; is_signed = 1'b0; dividend = 32'd9; divisor = 32'd3;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        if (busy) busy_cycles++;
    endtask

    initial begin
        int lat;
        int bcyc;
        int done_seen;

        repeat (3) @(negedge clk);
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_done", 64'(done), 64'd0);
        checkOutput("reset_quot", 64'(quotient), 64'd0);
        checkOutput("reset_rem", 64'(remainder), 64'd0);
        checkOutput("reset_dbz", 64'(div_by_zero), 64'd0);
        rst_n = 1'b1;

        applyStimulus(1'b0, 32'd100, 32'd7, 0, lat, bcyc);
        checkOutput("u100_7_latency", 64'(lat), 64'd34);
        checkOutput("u100_7_busy_cycles", 64'(bcyc), 64'd34);
        checkOutput("u100_7_quot", 64'(quotient), 64'd14);
        checkOutput("u100_7_rem", 64'(remainder), 64'd2);
        checkOutput("u100_7_dbz", 64'(div_by_zero), 64'd0);
        @(negedge clk);
        checkOutput("u100_7_idle_after", 64'(busy), 64'd0);
        checkOutput("u100_7_done_pulse", 64'(done), 64'd0);
        checkOutput("u100_7_quot_held", 64'(quotient), 64'd14);

        applyStimulus(1'b1, 32'hFFFF_FFF9, 32'd2, 0, lat, bcyc);
        checkOutput("sneg7_2_latency", 64'(lat), 64'd34);
        checkOutput("sneg7_2_quot", 64'(quotient), 64'h0000_0000_FFFF_FFFD);
        checkOutput("sneg7_2_rem", 64'(remainder), 64'h0000_0000_FFFF_FFFF);

        applyStimulus(1'b1, 32'd7, 32'hFFFF_FFFE, 0, lat, bcyc);
        checkOutput("s7_neg2_quot", 64'(quotient), 64'h0000_0000_FFFF_FFFD);
        checkOutput("s7_neg2_rem", 64'(remainder), 64'd1);

        applyStimulus(1'b0, 32'hFFFF_FFFF, 32'd1, 0, lat, bcyc);
        checkOutput("umax_1_quot", 64'(quotient), 64'h0000_0000_FFFF_FFFF);
        checkOutput("umax_1_rem", 64'(remainder), 64'd0);

        applyStimulus(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, lat, bcyc);
        checkOutput("smin_neg1_quot", 64'(quotient), 64'h0000_0000_8000_0000);
        checkOutput("smin_neg1_rem", 64'(remainder), 64'd0);
        checkOutput("smin_neg1_dbz", 64'(div_by_zero), 64'd0);

        applyStimulus(1'b0, 32'd5, 32'd0, 0, lat, bcyc);
        checkOutput("dbz5_latency", 64'(lat), 64'd1);
        checkOutput("dbz5_quot", 64'(quotient), 64'h0000_0000_FFFF_FFFF);
        checkOutput("dbz5_rem", 64'(remainder), 64'd5);
        checkOutput("dbz5_dbz", 64'(div_by_zero), 64'd1);

        applyStimulus(1'b1, 32'hFFFF_FFF8, 32'd0, 0, lat, bcyc);
        checkOutput("sdbz_neg8_rem", 64'(remainder), 64'h0000_0000_FFFF_FFF8);
        checkOutput("sdbz_neg8_dbz", 64'(div_by_zero), 64'd1);

        applyStimulus(1'b0, 32'd100, 32'd7, 10, lat, bcyc);
        checkOutput("ignored_start_latency", 64'(lat), 64'd34);
        checkOutput("ignored_start_quot", 64'(quotient), 64'd14);
        checkOutput("ignored_start_rem", 64'(remainder), 64'd2);
        checkOutput("ignored_start_dbz", 64'(div_by_zero), 64'd0);
        @(negedge clk);
        checkOutput("ignored_start_idle", 64'(busy), 64'd0);

        // Abort an operation with reset after 20 cycles; held results must clear.
        done_seen = 0;
        @(negedge clk);
        start = 1'b1; is_signed = 1'b0; dividend = 32'd1000; divisor = 32'd3;
        @(negedge clk);
        start = 1'b0;
        for (int i = 2; i <= 20; i++) begin
            if (done) done_seen++;
            @(negedge clk);
        end
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("midreset_busy", 64'(busy), 64'd0);
        checkOutput("midreset_quot", 64'(quotient), 64'd0);
        checkOutput("midreset_rem", 64'(remainder), 64'd0);
        checkOutput("midreset_dbz", 64'(div_by_zero), 64'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (done) done_seen++;
            @(negedge clk);
        end
        checkOutput("midreset_no_done", 64'(done_seen), 64'd0);

        applyStimulus(1'b0, 32'd1000, 32'd10, 0, lat, bcyc);
        checkOutput("post_reset_latency", 64'(lat), 64'd34);
        checkOutput("post_reset_quot", 64'(quotient), 64'd100);
        checkOutput("post_reset_rem", 64'(remainder), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
